tc_pl_spi_master: RTL

TC_PL_SPI_MASTER -- requirements
Module: tc_pl_spi_master

---
 rtl/tc_pl_spi_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tc_pl_spi_master.sv
// SPI mode-0 master: one command per transaction, MSB first, right-aligned data.
// Malformed commands are answered with an error response and never touch the bus.
module tc_pl_spi_master #(
  parameter int unsigned AGP0_25 = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [AGP0_25-1:0] cmd_sel,
  input  logic [5:0]         cmd_len,
  input  logic [31:0]        cmd_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               busy,
  output logic [AGP0_25-1:0] chip_sel,
  output logic               spi_CSN,
  output logic               spi_SCLK,
  output logic               spi_MOSI,
  input  logic               spi_MISO
);

  typedef enum logic [2:0] {StIdle, StSetup, StShiftH, StShiftL, StHold, StGap} state_e;

  localparam logic [7:0]         CntLoad = 8'(CLK_DIV - 1);
  localparam logic [AGP0_25-1:0] SelOne  = AGP0_25'(1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [5:0]         bits_q, bits_d;
  logic [31:0]        sdo_q, sdo_d;
  logic [31:0]        sdi_q, sdi_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [AGP0_25-1:0] cs_q, cs_d;
  logic               csn_q, csn_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;

  logic        accept;
  logic        sel_ok;
  logic        len_ok;
  logic        phase_done;
  logic [31:0] wd_aligned;

  assign cmd_ready  = (state_q == StIdle) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state_q != StIdle) || accept;
  assign sel_ok     = (cmd_sel != '0) && ((cmd_sel & (cmd_sel - SelOne)) == '0);
  assign len_ok     = (cmd_len != 6'd0) && (cmd_len <= 6'd32);
  assign phase_done = (cnt_q == 8'd0);
  // Left-align the payload so the next bit to send is always sdo[31].
  assign wd_aligned = cmd_wdata << (6'd32 - cmd_len);

  always_comb begin
    state_d     = state_q;
    cnt_d       = phase_done ? cnt_q : cnt_q - 8'd1;
    bits_d      = bits_q;
    sdo_d       = sdo_q;
    sdi_d       = sdi_q;
    rdata_d     = rdata_q;
    cs_d        = cs_q;
    csn_d       = csn_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          bits_d = cmd_len;
          sdi_d  = '0;
          cnt_d  = CntLoad;
          if (len_ok && sel_ok) begin
            state_d = StSetup;
            csn_d   = 1'b0;
            cs_d    = cmd_sel;
            sdo_d   = wd_aligned;
            mosi_d  = wd_aligned[31];
          end else begin
            state_d     = StGap;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = '0;
          end
        end
      end
      StSetup: begin
        if (phase_done) begin
          state_d = StShiftH;
          sclk_d  = 1'b1;
          cnt_d   = CntLoad;
        end
      end
      StShiftH: begin
        if (cnt_q == CntLoad) begin
          sdi_d = {sdi_q[30:0], spi_MISO};
        end
        if (phase_done) begin
          sclk_d = 1'b0;
          cnt_d  = CntLoad;
          if (bits_q == 6'd1) begin
            state_d = StHold;
          end else begin
            state_d = StShiftL;
            bits_d  = bits_q - 6'd1;
            sdo_d   = sdo_q << 1;
            mosi_d  = sdo_q[30];
          end
        end
      end
      StShiftL: begin
        if (phase_done) begin
          state_d = StShiftH;
          sclk_d  = 1'b1;
          cnt_d   = CntLoad;
        end
      end
      StHold: begin
        if (phase_done) begin
          state_d     = StGap;
          csn_d       = 1'b1;
          cs_d        = '0;
          mosi_d      = 1'b0;
          cnt_d       = CntLoad;
          rsp_valid_d = 1'b1;
          rdata_d     = sdi_q;
        end
      end
      StGap: begin
        if (phase_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      bits_q      <= 6'd0;
      sdo_q       <= '0;
      sdi_q       <= '0;
      rdata_q     <= '0;
      cs_q        <= '0;
      csn_q       <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      sdo_q       <= sdo_d;
      sdi_q       <= sdi_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      csn_q       <= csn_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign chip_sel  = cs_q;
  assign spi_CSN   = csn_q;
  assign spi_SCLK  = sclk_q;
  assign spi_MOSI  = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;

endmodule
